// File: rtl/bcd2bin.sv
// Sequential 3-digit BCD to 8-bit binary converter (reverse double-dabble, 8 iterations).
// Define BCD2BIN_CHECK_EN to flag invalid digits/out-of-range values with err and q=8'hFF.
module bcd2bin (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [1:0] hundreds,
   input  logic [3:0] tens,
   input  logic [3:0] ones,
   output logic [7:0] q,
   output logic       busy,
   output logic       done,
   output logic       err
);

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      FINISH
   } stateType;

   stateType   state;
   stateType   nextState;
   logic       accept;
   logic [9:0] bcdReg;
   logic [7:0] binReg;
   logic [2:0] iterCount;
   logic [17:0] shifted;
   logic [9:0] correctedBcd;

   // State register; reset drops any conversion in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   // Start is only honoured in IDLE, which is also the state during the done cycle.
   always_comb begin
      nextState = state;
      accept    = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               nextState = SHIFT;
               accept    = 1'b1;
            end
         end
         SHIFT: begin
            if (iterCount == 3'd7) begin
               nextState = FINISH;
            end
         end
         FINISH: begin
            nextState = IDLE;
         end
         default: begin
            nextState = IDLE;
         end
      endcase
   end

   assign busy = (state != IDLE);

   // One reverse double-dabble step; the 2-bit hundreds field can never reach 8 after a shift.
   always_comb begin
      shifted      = {bcdReg, binReg} >> 1;
      correctedBcd = shifted[17:8];
      if (shifted[15:12] >= 4'd8) begin
         correctedBcd[7:4] = shifted[15:12] - 4'd3;
      end
      if (shifted[11:8] >= 4'd8) begin
         correctedBcd[3:0] = shifted[11:8] - 4'd3;
      end
   end

   // Datapath: latch digits on accept, iterate while shifting.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bcdReg    <= 10'd0;
         binReg    <= 8'd0;
         iterCount <= 3'd0;
      end else if (accept) begin
         bcdReg    <= {hundreds, tens, ones};
         binReg    <= 8'd0;
         iterCount <= 3'd0;
      end else if (state == SHIFT) begin
         bcdReg    <= correctedBcd;
         binReg    <= shifted[7:0];
         iterCount <= iterCount + 3'd1;
      end
   end

`ifdef BCD2BIN_CHECK_EN
   logic [9:0] inputValue;
   logic       inputInvalid;
   logic       invalidReg;

   // Validity is judged on the digits present at the accepting edge.
   always_comb begin
      inputValue   = ({8'd0, hundreds} * 10'd100) + ({6'd0, tens} * 10'd10) + {6'd0, ones};
      inputInvalid = (tens > 4'd9) || (ones > 4'd9) || (hundreds == 2'd3) || (inputValue > 10'd255);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         invalidReg <= 1'b0;
      end else if (accept) begin
         invalidReg <= inputInvalid;
      end
   end

   // Result registers only change on the finishing edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q    <= 8'h00;
         err  <= 1'b0;
         done <= 1'b0;
      end else begin
         done <= (state == FINISH);
         if (state == FINISH) begin
            q   <= invalidReg ? 8'hFF : binReg;
            err <= invalidReg;
         end
      end
   end
`else
   assign err = 1'b0;

   // Result registers only change on the finishing edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q    <= 8'h00;
         done <= 1'b0;
      end else begin
         done <= (state == FINISH);
         if (state == FINISH) begin
            q <= binReg;
         end
      end
   end
`endif

endmodule

// File: tb/tb_bcd2bin.sv
// Self-checking bench for bcd2bin: arithmetic reference model checked every cycle,
// directed scenarios with literal results, and a randomized stimulus phase.
module tb_bcd2bin;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [1:0] hundreds;
   logic [3:0] tens;
   logic [3:0] ones;
   logic [7:0] q;
   logic       busy;
   logic       done;
   logic       err;

   int checks   = 0;
   int failures = 0;

`ifdef BCD2BIN_CHECK_EN
   localparam bit checkEn = 1'b1;
`else
   localparam bit checkEn = 1'b0;
`endif

   // Reference model state: cycles remaining until the result appears.
   int       mCount    = 0;
   int       mValue    = 0;
   bit       mInvalid  = 1'b0;
   bit       expDone   = 1'b0;
   bit       expErr    = 1'b0;
   bit       expQKnown = 1'b1;
   logic [7:0] expQ    = 8'h00;

   bcd2bin dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .hundreds (hundreds),
      .tens     (tens),
      .ones     (ones),
      .q        (q),
      .busy     (busy),
      .done     (done),
      .err      (err)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
      end
   endtask

   // Model: a request takes 9 edges after acceptance, then the result shows for one cycle.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         mCount    = 0;
         expDone   = 1'b0;
         expQ      = 8'h00;
         expErr    = 1'b0;
         expQKnown = 1'b1;
      end else begin
         expDone = 1'b0;
         if (mCount > 0) begin
            mCount--;
            if (mCount == 0) begin
               expDone = 1'b1;
               if (mInvalid && checkEn) begin
                  expQ      = 8'hFF;
                  expErr    = 1'b1;
                  expQKnown = 1'b1;
               end else begin
                  expErr = 1'b0;
                  if (mInvalid) begin
                     expQKnown = 1'b0;
                  end else begin
                     expQ      = mValue[7:0];
                     expQKnown = 1'b1;
                  end
               end
            end
         end else if (start) begin
            mCount   = 9;
            mValue   = int'(hundreds) * 100 + int'(tens) * 10 + int'(ones);
            mInvalid = (tens > 4'd9) || (ones > 4'd9) || (hundreds == 2'd3) || (mValue > 255);
         end
      end
      #1;
      checkOutput("modelBusy", int'(busy), int'(mCount > 0));
      checkOutput("modelDone", int'(done), int'(expDone));
      checkOutput("modelErr", int'(err), int'(expErr));
      if (expQKnown) begin
         checkOutput("modelQ", int'(q), int'(expQ));
      end
   end

   task automatic applyStimulus(input logic [1:0] h, input logic [3:0] t, input logic [3:0] o,
                                input logic s);
      @(negedge clk);
      hundreds = h;
      tens     = t;
      ones     = o;
      start    = s;
   endtask

   // One-cycle start, then wait (bounded) for done while counting busy cycles.
   task automatic convert(input logic [1:0] h, input logic [3:0] t, input logic [3:0] o,
                          output int busyCycles, output bit gotDone);
      applyStimulus(h, t, o, 1'b1);
      @(negedge clk);
      start      = 1'b0;
      busyCycles = 0;
      gotDone    = 1'b0;
      for (int i = 0; i < 20 && !gotDone; i++) begin
         if (done) begin
            gotDone = 1'b1;
         end else begin
            if (busy) busyCycles++;
            @(negedge clk);
         end
      end
      if (!gotDone) checkOutput("doneTimeout", 0, 1);
   endtask

   initial begin
      int  busyCycles;
      bit  gotDone;
      int  doneCount;
      int  lastDone;

      rst      = 1'b1;
      start    = 1'b0;
      hundreds = 2'd0;
      tens     = 4'd0;
      ones     = 4'd0;
      repeat (3) @(negedge clk);
      checkOutput("resetQ", int'(q), 0);
      checkOutput("resetBusy", int'(busy), 0);
      checkOutput("resetDone", int'(done), 0);
      checkOutput("resetErr", int'(err), 0);
      rst = 1'b0;

      // 255: nine busy cycles, all-ones result.
      convert(2'd2, 4'd5, 4'd5, busyCycles, gotDone);
      checkOutput("maxBusyCycles", busyCycles, 9);
      checkOutput("maxQ", int'(q), 255);
      checkOutput("maxErr", int'(err), 0);

      // Start re-pulsed mid-conversion must be ignored.
      applyStimulus(2'd1, 4'd2, 4'd8, 1'b1);
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      hundreds = 2'd0;
      tens     = 4'd0;
      ones     = 4'd7;
      start    = 1'b1;
      @(negedge clk);
      start     = 1'b0;
      doneCount = 0;
      for (int i = 0; i < 20; i++) begin
         if (done) begin
            doneCount++;
            checkOutput("ignoreRestartQ", int'(q), 128);
         end
         @(negedge clk);
      end
      checkOutput("ignoreRestartDones", doneCount, 1);

      // Reset mid-conversion aborts it.
      applyStimulus(2'd0, 4'd9, 4'd9, 1'b1);
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      checkOutput("abortQ", int'(q), 0);
      checkOutput("abortBusy", int'(busy), 0);
      checkOutput("abortDone", int'(done), 0);
      @(negedge clk);
      rst       = 1'b0;
      doneCount = 0;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         if (done) doneCount++;
      end
      checkOutput("abortNoDone", doneCount, 0);
      convert(2'd0, 4'd4, 4'd2, busyCycles, gotDone);
      checkOutput("afterAbortQ", int'(q), 42);

      // Full sweep of valid inputs.
      doneCount = 0;
      for (int v = 0; v < 256; v++) begin
         convert(2'(v / 100), 4'((v / 10) % 10), 4'(v % 10), busyCycles, gotDone);
         if (gotDone) doneCount++;
         checkOutput("sweepQ", int'(q), v);
      end
      checkOutput("sweepDones", doneCount, 256);

`ifdef BCD2BIN_CHECK_EN
      convert(2'd0, 4'd10, 4'd0, busyCycles, gotDone);
      checkOutput("badTensErr", int'(err), 1);
      checkOutput("badTensQ", int'(q), 255);
      convert(2'd2, 4'd5, 4'd6, busyCycles, gotDone);
      checkOutput("overRangeErr", int'(err), 1);
      checkOutput("overRangeQ", int'(q), 255);
      checkOutput("overRangeBusy", busyCycles, 9);
      convert(2'd3, 4'd0, 4'd0, busyCycles, gotDone);
      checkOutput("badHundredsErr", int'(err), 1);
      checkOutput("badHundredsQ", int'(q), 255);
      convert(2'd0, 4'd0, 4'd0, busyCycles, gotDone);
      checkOutput("zeroErr", int'(err), 0);
      checkOutput("zeroQ", int'(q), 0);
`endif

      // Start held high: back-to-back conversions every 10 cycles.
      applyStimulus(2'd0, 4'd1, 4'd7, 1'b1);
      doneCount = 0;
      lastDone  = -1;
      for (int i = 0; i < 62; i++) begin
         @(negedge clk);
         if (done) begin
            doneCount++;
            checkOutput("heldQ", int'(q), 17);
            if (lastDone >= 0) checkOutput("heldPeriod", i - lastDone, 10);
            lastDone = i;
         end
      end
      checkOutput("heldDones", doneCount, 6);
      start = 1'b0;
      repeat (12) @(negedge clk);

      // Randomized phase: digits change every cycle, occasional resets.
      for (int i = 0; i < 1500; i++) begin
         @(negedge clk);
         if ($urandom_range(0, 199) == 0) begin
            rst = 1'b1;
         end else begin
            rst = 1'b0;
         end
         hundreds = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
         tens     = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
         ones     = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
         start    = ($urandom_range(0, 2) == 0);
      end
      @(negedge clk);
      rst   = 1'b0;
      start = 1'b0;
      repeat (12) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/bcd2bin.md
BCD2BIN -- requirements
Module: bcd2bin

Interface
REQ-001 The module SHALL have no parameters; widths are fixed (3-digit BCD in, 8-bit binary out).
REQ-002 CLK  input  1  single clock; all state updates on rising edge.
REQ-003 RST  input  1  reset, asynchronous, active-high.
REQ-004 START  input  1  conversion request, sampled on CLK rising edge.
REQ-005 HUNDREDS  input  2  BCD hundreds digit.
REQ-006 TENS  input  4  BCD tens digit.
REQ-007 ONES  input  4  BCD ones digit.
REQ-008 Q  output  8  binary result, registered.
REQ-009 BUSY  output  1  high while a conversion is in progress.
REQ-010 DONE  output  1  one-cycle pulse; Q/ERR valid in that cycle.
REQ-011 ERR  output  1  invalid-input flag, registered, valid with DONE.

Function
REQ-012 FSM states SHALL be IDLE, SHIFT, FINISH; reset state IDLE.
REQ-013 In IDLE with START=1 at edge E0: digits latched into a 10-bit BCD register; 8-bit shift register cleared; iteration counter = 0; state -> SHIFT; BUSY=1 from E0.
REQ-014 Each SHIFT edge SHALL perform one reverse double-dabble iteration: shift {BCD,bin} right by 1; then, per BCD digit (hundreds, tens, ones), subtract 3 if digit >= 8.
REQ-015 Iterations SHALL occur on edges E1..E8; on E8 state -> FINISH.
REQ-016 On E9 (FINISH): Q <= shift register, DONE=1, BUSY=0, state -> IDLE; DONE SHALL drop at E10.
REQ-017 Fixed latency: DONE high exactly in the cycle after edge E9, for every input.
REQ-018 START while BUSY=1 or in FINISH SHALL be ignored; latched digits SHALL not change until the next accepted START.
REQ-019 START high in the cycle DONE is high SHALL be accepted (back-to-back conversions, one idle-free restart).
REQ-020 Q and ERR SHALL hold their last values between DONE pulses, including while BUSY.
REQ-021 Input digits MAY change after E0 without affecting the conversion in progress.

Reset
REQ-022 RST=1 SHALL immediately force Q=8'h00, ERR=0, DONE=0, BUSY=0, counter=0, state IDLE, independent of CLK.
REQ-023 RST asserted mid-conversion SHALL abort it; no DONE pulse SHALL follow for the aborted request.
REQ-024 First START after RST deassertion SHALL be accepted on the first rising edge with RST=0.

Configuration
REQ-025 Macro BCD2BIN_CHECK_EN SHALL control input validation.
REQ-026 With BCD2BIN_CHECK_EN defined: at E0, input is invalid if TENS>9, ONES>9, HUNDREDS=3, or value>255; invalid request SHALL still take the full latency, then DONE=1, ERR=1, Q=8'hFF.
REQ-027 With BCD2BIN_CHECK_EN undefined: ERR SHALL be constant 0; Q for invalid inputs is unspecified and not checked; valid-input behaviour identical.

Verification
REQ-028 RST pulse, then HUNDREDS=2,TENS=5,ONES=5, START 1 cycle -> BUSY high 9 cycles, DONE 1 cycle after E9, Q=8'hFF, ERR=0.
REQ-029 Sweep all valid inputs 000..255, one START each after DONE -> Q equals decimal value every time; DONE count = 256.
REQ-030 HUNDREDS=1,TENS=2,ONES=8 START; START re-pulsed at E3 with 0,0,7 -> single DONE, Q=8'd128; 0,0,7 not converted.
REQ-031 Start 0,9,9; assert RST at E4 for 1 cycle -> Q=0, BUSY=0 immediately, no DONE; new START 0,4,2 -> Q=8'd42.
REQ-032 With BCD2BIN_CHECK_EN: inputs 0,10,0 then 2,5,6 then 3,0,0 -> each DONE with ERR=1, Q=8'hFF; next 0,0,0 -> ERR=0, Q=0.
REQ-033 START held high continuously with 0,1,7 -> DONE every 10 cycles, Q=8'd17 each time.
